// File: rtl/key_dir_filter.sv
// Turns four raw HID keycode slots into one debounced W/A/S/D direction per frame (most recent held key wins).
// Optional KEYFILT_STICKY_EN: keycode_out keeps the last direction once no key is held.
module key_dir_filter #(
    parameter int         DEBOUNCE = 2,
    parameter logic [7:0] CODE_W   = 8'h1A,
    parameter logic [7:0] CODE_A   = 8'h04,
    parameter logic [7:0] CODE_S   = 8'h16,
    parameter logic [7:0] CODE_D   = 8'h07
) (
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode0,
    input  logic [7:0] keycode1,
    input  logic [7:0] keycode2,
    input  logic [7:0] keycode3,
    output logic [7:0] keycode_out,
    output logic       key_valid,
    output logic       key_change
);

    localparam logic [2:0] DB = 3'(DEBOUNCE);

    logic [7:0] r_slot [4];
    logic [2:0] r_dcnt [4];
    logic [1:0] r_stk  [4];
    logic [2:0] r_stk_cnt;
    logic       r_change;

    logic [3:0] w_press;
    logic [3:0] w_hold;
    logic [3:0] w_rel;
    logic [1:0] w_nstk [4];
    logic [2:0] w_ncnt;
    logic [7:0] w_top_code;
    logic [7:0] w_next_top_code;
    logic [7:0] w_next_out;

    // Key IDs: 0=W, 1=A, 2=S, 3=D
    function automatic logic [7:0] code_of(input logic [1:0] id);
        case (id)
            2'd0:    code_of = CODE_W;
            2'd1:    code_of = CODE_A;
            2'd2:    code_of = CODE_S;
            default: code_of = CODE_D;
        endcase
    endfunction

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            for (int s = 0; s < 4; s++) r_slot[s] <= 8'h00;
        end else begin
            r_slot[0] <= keycode0;
            r_slot[1] <= keycode1;
            r_slot[2] <= keycode2;
            r_slot[3] <= keycode3;
        end
    end

    always_comb begin
        w_press = 4'b0000;
        for (int s = 0; s < 4; s++) begin
            if (r_slot[s] == CODE_W) w_press[0] = 1'b1;
            if (r_slot[s] == CODE_A) w_press[1] = 1'b1;
            if (r_slot[s] == CODE_S) w_press[2] = 1'b1;
            if (r_slot[s] == CODE_D) w_press[3] = 1'b1;
        end
    end

    // Hold/release fire on the very edge the counter reaches or leaves DEBOUNCE.
    always_comb begin
        w_hold = 4'b0000;
        w_rel  = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            w_hold[k] = w_press[k] && (r_dcnt[k] == DB - 3'd1);
            w_rel[k]  = !w_press[k] && (r_dcnt[k] == DB);
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            for (int k = 0; k < 4; k++) r_dcnt[k] <= 3'd0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (!w_press[k])        r_dcnt[k] <= 3'd0;
                else if (r_dcnt[k] != DB) r_dcnt[k] <= r_dcnt[k] + 3'd1;
            end
        end
    end

    // Compact out released entries first, then push new holds in W,A,S,D order.
    always_comb begin
        w_nstk = r_stk;
        w_ncnt = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if ((3'(i) < r_stk_cnt) && !w_rel[r_stk[i]]) begin
                w_nstk[w_ncnt[1:0]] = r_stk[i];
                w_ncnt              = w_ncnt + 3'd1;
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (w_hold[k] && (w_ncnt < 3'd4)) begin
                w_nstk[w_ncnt[1:0]] = 2'(k);
                w_ncnt              = w_ncnt + 3'd1;
            end
        end
    end

    assign w_top_code      = code_of(r_stk[2'(r_stk_cnt - 3'd1)]);
    assign w_next_top_code = code_of(w_nstk[2'(w_ncnt - 3'd1)]);

`ifdef KEYFILT_STICKY_EN
    logic [7:0] r_last;

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) r_last <= 8'h00;
        else       r_last <= w_next_out;
    end

    assign w_next_out  = (w_ncnt != 3'd0) ? w_next_top_code : r_last;
    assign keycode_out = (r_stk_cnt != 3'd0) ? w_top_code : r_last;
`else
    assign w_next_out  = (w_ncnt != 3'd0) ? w_next_top_code : 8'h00;
    assign keycode_out = (r_stk_cnt != 3'd0) ? w_top_code : 8'h00;
`endif

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < 4; i++) r_stk[i] <= 2'd0;
            r_stk_cnt <= 3'd0;
            r_change  <= 1'b0;
        end else begin
            r_stk     <= w_nstk;
            r_stk_cnt <= w_ncnt;
            r_change  <= (w_next_out != keycode_out);
        end
    end

    assign key_valid  = (r_stk_cnt != 3'd0);
    assign key_change = r_change;

endmodule

// File: tb/tb_key_dir_filter.sv
// Bench for key_dir_filter: directed scenarios plus randomized slot traffic against a hold-order queue model.
module tb_key_dir_filter;

    localparam int DB = 2;
`ifdef KEYFILT_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic       Reset;
    logic       frame_clk;
    logic [7:0] keycode0, keycode1, keycode2, keycode3;
    logic [7:0] keycode_out;
    logic       key_valid;
    logic       key_change;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: input streaks, hold-order queue, last output.
    int         streak [4];
    bit         m_held [4];
    int         held_q [$];
    logic [7:0] m_out;
    logic [7:0] m_last;
    logic       m_change;

    key_dir_filter dut (
        .Reset       (Reset),
        .frame_clk   (frame_clk),
        .keycode0    (keycode0),
        .keycode1    (keycode1),
        .keycode2    (keycode2),
        .keycode3    (keycode3),
        .keycode_out (keycode_out),
        .key_valid   (key_valid),
        .key_change  (key_change)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    function automatic logic [7:0] key_code(input int id);
        case (id)
            0:       return 8'h1A;
            1:       return 8'h04;
            2:       return 8'h16;
            default: return 8'h07;
        endcase
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_out"},    keycode_out,       m_out);
        check({tag, "_valid"},  {7'd0, key_valid}, {7'd0, held_q.size() != 0});
        check({tag, "_change"}, {7'd0, key_change}, {7'd0, m_change});
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            streak[k] = 0;
            m_held[k] = 1'b0;
        end
        held_q.delete();
        m_out    = 8'h00;
        m_last   = 8'h00;
        m_change = 1'b0;
    endtask

    // One frame edge: a key counts as held once DB consecutive earlier samples contained it.
    task automatic model_edge(input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d);
        bit         now_h [4];
        logic [7:0] new_out;
        for (int k = 0; k < 4; k++) begin
            now_h[k] = (streak[k] >= DB);
            if (a == key_code(k) || b == key_code(k) || c == key_code(k) || d == key_code(k))
                streak[k] = streak[k] + 1;
            else
                streak[k] = 0;
        end
        for (int i = held_q.size() - 1; i >= 0; i--)
            if (!now_h[held_q[i]]) held_q.delete(i);
        for (int k = 0; k < 4; k++)
            if (now_h[k] && !m_held[k]) held_q.push_back(k);
        for (int k = 0; k < 4; k++) m_held[k] = now_h[k];
        if (held_q.size() != 0) new_out = key_code(held_q[$]);
        else                    new_out = STICKY ? m_last : 8'h00;
        if (held_q.size() != 0) m_last = new_out;
        m_change = (new_out != m_out);
        m_out    = new_out;
    endtask

    task automatic step(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic [7:0] d);
        keycode0 = a;
        keycode1 = b;
        keycode2 = c;
        keycode3 = d;
        @(posedge frame_clk);
        model_edge(a, b, c, d);
        @(negedge frame_clk);
        check_model(tag);
    endtask

    // Called at a negedge; asserts Reset between edges and checks the asynchronous clear.
    task automatic apply_reset(input string tag);
        #2 Reset = 1'b1;
        #1;
        model_reset();
        check({tag, "_out"},    keycode_out,        8'h00);
        check({tag, "_valid"},  {7'd0, key_valid},  8'h00);
        check({tag, "_change"}, {7'd0, key_change}, 8'h00);
        @(posedge frame_clk);
        @(negedge frame_clk);
        Reset = 1'b0;
    endtask

    function automatic logic [7:0] pick_code();
        int r;
        r = $urandom_range(0, 9);
        case (r)
            0, 1, 2: return 8'h00;
            3, 8:    return 8'h1A;
            4:       return 8'h04;
            5:       return 8'h16;
            6, 9:    return 8'h07;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        logic [7:0] rs [4];
        Reset    = 1'b0;
        keycode0 = 8'h00;
        keycode1 = 8'h00;
        keycode2 = 8'h00;
        keycode3 = 8'h00;
        model_reset();
        @(negedge frame_clk);
        apply_reset("por");

        // W press latency
        step("w_e0", 8'h1A, 8'h00, 8'h00, 8'h00);
        check("w_e0_const", keycode_out, 8'h00);
        step("w_e1", 8'h1A, 8'h00, 8'h00, 8'h00);
        check("w_e1_const", keycode_out, 8'h00);
        step("w_e2", 8'h1A, 8'h00, 8'h00, 8'h00);
        check("w_e2_const", keycode_out, 8'h1A);
        check("w_e2_change", {7'd0, key_change}, 8'h01);
        check("w_e2_valid", {7'd0, key_valid}, 8'h01);
        step("w_e3", 8'h1A, 8'h00, 8'h00, 8'h00);
        check("w_e3_change", {7'd0, key_change}, 8'h00);

        // Single-frame A glitch
        step("gl0", 8'h1A, 8'h04, 8'h00, 8'h00);
        for (int i = 0; i < 3; i++) step("gl", 8'h1A, 8'h00, 8'h00, 8'h00);
        check("gl_const", keycode_out, 8'h1A);

        // D over W, then drop D
        step("d0", 8'h1A, 8'h00, 8'h07, 8'h00);
        step("d1", 8'h1A, 8'h00, 8'h07, 8'h00);
        step("d2", 8'h1A, 8'h00, 8'h07, 8'h00);
        check("d2_const", keycode_out, 8'h07);
        step("dr0", 8'h1A, 8'h00, 8'h00, 8'h00);
        check("dr0_const", keycode_out, 8'h07);
        step("dr1", 8'h1A, 8'h00, 8'h00, 8'h00);
        check("dr1_const", keycode_out, 8'h1A);
        check("dr1_change", {7'd0, key_change}, 8'h01);

        // All four in one frame, then remove D and S together
        apply_reset("rst2");
        for (int i = 0; i < 3; i++) step("all", 8'h1A, 8'h04, 8'h16, 8'h07);
        check("all_const", keycode_out, 8'h07);
        step("ds0", 8'h1A, 8'h04, 8'h00, 8'h00);
        step("ds1", 8'h1A, 8'h04, 8'h00, 8'h00);
        check("ds1_const", keycode_out, 8'h04);

        // Release A and press S in the same frame
        apply_reset("rst3");
        for (int i = 0; i < 3; i++) step("a", 8'h00, 8'h04, 8'h00, 8'h00);
        check("a_const", keycode_out, 8'h04);
        step("as0", 8'h00, 8'h16, 8'h00, 8'h00);
        step("as1", 8'h00, 8'h16, 8'h00, 8'h00);
        check("as1_const", keycode_out, STICKY ? 8'h04 : 8'h00);
        check("as1_valid", {7'd0, key_valid}, 8'h00);
        step("as2", 8'h00, 8'h16, 8'h00, 8'h00);
        check("as2_const", keycode_out, 8'h16);

        // Async reset while S is output; S must re-debounce
        apply_reset("rst_mid");
        step("rs0", 8'h00, 8'h16, 8'h00, 8'h00);
        step("rs1", 8'h00, 8'h16, 8'h00, 8'h00);
        check("rs1_const", keycode_out, 8'h00);
        step("rs2", 8'h00, 8'h16, 8'h00, 8'h00);
        check("rs2_const", keycode_out, 8'h16);

        // Randomized traffic with persistent slots and occasional resets
        for (int s = 0; s < 4; s++) rs[s] = 8'h00;
        for (int n = 0; n < 600; n++) begin
            for (int s = 0; s < 4; s++)
                if ($urandom_range(0, 9) >= 7) rs[s] = pick_code();
            if ($urandom_range(0, 149) == 0) apply_reset("rnd_rst");
            step("rnd", rs[0], rs[1], rs[2], rs[3]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/key_dir_filter.md
Name: key_dir_filter

Overview:
- Sits directly upstream of the ball motion block.
- Converts the four raw HID keycode slots, written by the NIOS II USB driver, into one debounced direction keycode per frame.
- Priority: the most recently pressed W/A/S/D key that is still held wins. On release, the output falls back to the next most recent held key.
- Output drives the ball block's keycode input; all logic runs on frame_clk.

Parameters:
- DEBOUNCE, 2, consecutive frames a key must be seen before it counts as pressed; legal range 1..7.
- CODE_W, 8'h1A, keycode for up.
- CODE_A, 8'h04, keycode for left.
- CODE_S, 8'h16, keycode for down.
- CODE_D, 8'h07, keycode for right.

Ports:
- Reset  input  1  reset, asynchronous, active-high.
- frame_clk  input  1  clock (vsync-rate frame clock).
- keycode0  input  8  HID report slot 0, 8'h00 = empty.
- keycode1  input  8  HID report slot 1.
- keycode2  input  8  HID report slot 2.
- keycode3  input  8  HID report slot 3.
- keycode_out  output  8  filtered direction keycode to the ball block; 8'h00 = none.
- key_valid  output  1  high while at least one debounced direction key is held.
- key_change  output  1  one-frame pulse on the edge where keycode_out changes value.

Behaviour:
- Reset (async, any time, including mid-debounce): clears
  - input sample registers,
  - debounce counters,
  - priority stack and stack count,
  - key_change.
  - Resulting outputs: keycode_out=8'h00, key_valid=0, key_change=0.
  - Keys still held when Reset deasserts must re-debounce from zero.
- Stage 1, sample: keycode0..3 are registered on every frame_clk edge.
- Stage 1, decode: from the sampled slots, form a pressed vector P[3:0] = {D,S,A,W}.
  - A key is present if any slot equals its code.
  - Duplicate codes across slots count as one.
  - Non-direction codes are ignored.
- Debounce, per key, 3-bit counter:
  - If P[k]=1, the counter increments, saturating at DEBOUNCE.
  - If P[k]=0, the counter clears immediately. There is no release debounce.
  - A key becomes "held" on the edge where its counter reaches DEBOUNCE.
  - A key becomes "released" on the edge where its counter clears from DEBOUNCE.
- Priority stack: 4 entries of 2-bit key IDs plus a count of 0..4. Entry[count-1] is the top.
  - New hold: push the key on top.
  - Release: remove that entry; entries above it shift down one place; count decrements.
  - Several new holds on the same edge: push in fixed order W, A, S, D, so D ends on top.
  - Release and new hold on the same edge: apply all removals first, then pushes.
  - A key never appears twice in the stack. Count cannot exceed 4, so overflow is impossible.
- Outputs:
  - keycode_out is combinational from the stack top: the code of entry[count-1] if count>0, else 8'h00.
  - key_valid = (count != 0).
  - key_change is registered: it is 1 for exactly the frame following an edge on which keycode_out's value changed.
- Latency:
  - Press: key on the inputs before edge 0 → keycode_out valid after edge DEBOUNCE (edge 2 at default).
  - Release: key removed before edge m → its entry is popped after edge m+1.
- Glitch rejection: a key present for fewer than DEBOUNCE consecutive sampled frames never reaches the stack.

Optional Feature:
- KEYFILT_STICKY_EN defined: when count drops to 0, keycode_out holds the last top-of-stack code. key_valid still goes 0, and key_change does not pulse. After Reset, keycode_out=8'h00 until the first hold.
- KEYFILT_STICKY_EN undefined: keycode_out=8'h00 whenever count=0.

Test Plan:
- Reset, then keycode0=8'h1A held steady → keycode_out=8'h00 after edges 0 and 1; 8'h1A after edge 2; key_change=1 for one frame; key_valid=1.
- keycode1=8'h04 for one frame only (DEBOUNCE=2) → keycode_out and key_valid never change; key_change stays 0.
- Hold W (debounced), add D in slot 2 → output 8'h07 two edges later; drop D → output back to 8'h1A one edge after the sample; key_change pulses on each transition.
- W, A, S, D all appear in the same frame → after edge 2 output is 8'h07; remove D and S together → output 8'h04.
- Hold A, release A and press S in the same frame → output 8'h00 (sticky off) or 8'h04 with key_valid=0 (sticky on); then 8'h16 after DEBOUNCE edges.
- Assert Reset asynchronously between edges while 8'h16 is output → keycode_out=8'h00 immediately; with S still held after Reset release, output 8'h16 returns only after 2 further edges.
